lsu_mem_arbiter: RTL and testbench
==================================

Name: lsu_mem_arbiter

Overview:
- Shares one data-memory port between NUM_LSUS load/store units.
- Serves exactly one transaction at a time. Grants are round-robin.
- Speaks the LSU valid/ready protocol on each requester port and a single combined read/write valid/ready port toward data memory.
- Sits between the per-thread LSUs of a core and the core's data-memory channel.

Parameters:
- NUM_LSUS, 4, number of requesting LSUs (>=2).
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.
- TIMEOUT_CYCLES, 64, WAIT-state abort limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- lsu_read_valid  in  NUM_LSUS  per-LSU read request.
- lsu_read_address  in  NUM_LSUS*ADDR_BITS  per-LSU read address; slice i = [i*ADDR_BITS +: ADDR_BITS].
- lsu_read_ready  out  NUM_LSUS  per-LSU read-complete pulse.
- lsu_read_data  out  NUM_LSUS*DATA_BITS  per-LSU read data.
- lsu_write_valid  in  NUM_LSUS  per-LSU write request.
- lsu_write_address  in  NUM_LSUS*ADDR_BITS  per-LSU write address.
- lsu_write_data  in  NUM_LSUS*DATA_BITS  per-LSU write data.
- lsu_write_ready  out  NUM_LSUS  per-LSU write-complete pulse.
- mem_valid  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_address  out  ADDR_BITS  memory address.
- mem_wdata  out  DATA_BITS  memory write data.
- mem_ready  in  1  memory completion.
- mem_rdata  in  DATA_BITS  memory read data, valid while mem_ready = 1.
- grant_id  out  $clog2(NUM_LSUS)  index of the LSU being served.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky abort flag; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, all outputs 0, lsu_read_data all 0.
- All outputs are registered.
- Requester protocol: an LSU holds valid, address and data stable until it sees its ready=1. Ready is a one-cycle pulse. The LSU drops valid on the edge where it samples ready.
- State IDLE:
  - Scan LSUs rr_ptr, rr_ptr+1, ... mod NUM_LSUS; pick the first with read_valid or write_valid.
  - On a hit, register mem_valid=1, mem_we, mem_address and mem_wdata from that LSU; set grant_id; go to WAIT.
  - No hit: stay in IDLE.
- State WAIT:
  - mem_valid is held, with address and data stable.
  - On mem_ready=1: mem_valid<=0.
  - For a read: lsu_read_data[grant] <= mem_rdata, lsu_read_ready[grant] <= 1.
  - For a write: lsu_write_ready[grant] <= 1.
  - Set rr_ptr <= (grant+1) mod NUM_LSUS; go to RELEASE.
- State RELEASE: clear the ready pulse; go to IDLE. This one cycle guarantees the served LSU's valid has fallen before re-arbitration.
- Latency: request sampled at edge E0 -> mem_valid high after E0. mem_ready sampled at Ek -> LSU ready high after Ek. Back-to-back transactions to different LSUs are therefore at least 3 cycles apart when memory answers in one cycle.
- Same LSU asserts read and write together: write is served first. The read stays pending and competes in later rounds under the normal rr_ptr order.
- lsu_read_data[i] holds its last value until LSU i's next read completes.
- mem_ready while in IDLE or RELEASE: ignored.
- A requester dropping valid while granted is a protocol violation. The transaction still completes; no check is made.
- Reset asserted mid-transaction: immediate abort to IDLE; mem_valid falls asynchronously.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT. If mem_ready is not seen within TIMEOUT_CYCLES cycles:
  - mem_valid <= 0.
  - The granted LSU receives its ready pulse anyway; read data is all-ones.
  - timeout_err is set (sticky until reset).
  - Then RELEASE, then IDLE; rr_ptr advances as normal.
- Undefined: no counter; WAIT waits indefinitely; timeout_err is constant 0.

Test Plan:
- Single read: LSU2 reads addr 0x40, memory returns 0xA5 after 3 cycles -> mem_valid/mem_we=0/mem_address=0x40, then lsu_read_data[2]=0xA5 with a 1-cycle lsu_read_ready[2].
- Single write: LSU1 writes 0x3C to 0x10 -> mem_we=1, mem_wdata=0x3C; one lsu_write_ready[1] pulse; no read-ready pulses.
- Fairness: all 4 LSUs request from reset, memory ready=1 -> grant order 0,1,2,3. Re-request after serving 1 and 2 -> next grant is 3 then 0.
- Simultaneous read+write on LSU0 alone -> write issued first, read next; each gets exactly one ready pulse.
- Reset asserted while in WAIT -> mem_valid=0 immediately; after release, re-arbitration starts from LSU0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready never asserted -> after 8 WAIT cycles the read returns 0xFF, timeout_err=1 and stays set.

Source files
------------

// File: rtl/lsu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_arbiter_if
// Brief    : LSU request/response bundle plus the shared data-memory channel.
// Revision : 1.0
// ============================================================================
interface lsu_mem_arbiter_if #(
  parameter int NUM_LSUS  = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [NUM_LSUS-1:0]           lsu_read_valid;
  logic [NUM_LSUS*ADDR_BITS-1:0] lsu_read_address;
  logic [NUM_LSUS-1:0]           lsu_read_ready;
  logic [NUM_LSUS*DATA_BITS-1:0] lsu_read_data;
  logic [NUM_LSUS-1:0]           lsu_write_valid;
  logic [NUM_LSUS*ADDR_BITS-1:0] lsu_write_address;
  logic [NUM_LSUS*DATA_BITS-1:0] lsu_write_data;
  logic [NUM_LSUS-1:0]           lsu_write_ready;
  logic                          mem_valid;
  logic                          mem_we;
  logic [ADDR_BITS-1:0]          mem_address;
  logic [DATA_BITS-1:0]          mem_wdata;
  logic                          mem_ready;
  logic [DATA_BITS-1:0]          mem_rdata;

  // master: the environment (LSUs and memory); slave: the arbiter
  modport master (
    output lsu_read_valid, lsu_read_address, lsu_write_valid,
           lsu_write_address, lsu_write_data, mem_ready, mem_rdata,
    input  lsu_read_ready, lsu_read_data, lsu_write_ready,
           mem_valid, mem_we, mem_address, mem_wdata
  );

  modport slave (
    input  lsu_read_valid, lsu_read_address, lsu_write_valid,
           lsu_write_address, lsu_write_data, mem_ready, mem_rdata,
    output lsu_read_ready, lsu_read_data, lsu_write_ready,
           mem_valid, mem_we, mem_address, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_arbiter
// Brief    : Round-robin sharing of one data-memory port between LSUs, one
//            transaction at a time. Optional macro ARB_TIMEOUT_EN adds a
//            WAIT-state abort after TIMEOUT_CYCLES cycles.
// Revision : 1.0
// ============================================================================
module lsu_mem_arbiter #(
  parameter int NUM_LSUS       = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic                        clk,
  input  wire logic                        reset,
  lsu_mem_arbiter_if.slave                 bus,
  output logic [$clog2(NUM_LSUS)-1:0]      grant_id,
  output logic                             busy,
  output logic                             timeout_err
);
  localparam int c_idx_w = $clog2(NUM_LSUS);
  localparam logic [c_idx_w:0]   c_num  = (c_idx_w+1)'(NUM_LSUS);
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NUM_LSUS - 1);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_wait    = 2'd1;
  localparam logic [1:0] c_st_release = 2'd2;

  logic [1:0]           r_state, w_state_nxt;
  logic [c_idx_w-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [c_idx_w-1:0]   r_grant, w_grant_nxt, w_pick;
  logic [c_idx_w:0]     w_sum;
  logic                 w_hit;
  logic                 r_mem_valid, w_mem_valid_nxt;
  logic                 r_mem_we, w_mem_we_nxt;
  logic [ADDR_BITS-1:0] r_mem_address, w_mem_address_nxt;
  logic [DATA_BITS-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [NUM_LSUS-1:0]  r_rd_ready, w_rd_ready_nxt;
  logic [NUM_LSUS-1:0]  r_wr_ready, w_wr_ready_nxt;
  logic [NUM_LSUS-1:0]  w_req;
  logic                 r_busy;
  logic                 w_rd_load;
  logic [DATA_BITS-1:0] w_rd_value;
  logic                 w_expire;
  logic [DATA_BITS-1:0] r_rd_data [NUM_LSUS];
  logic [ADDR_BITS-1:0] w_rd_addr [NUM_LSUS];
  logic [ADDR_BITS-1:0] w_wr_addr [NUM_LSUS];
  logic [DATA_BITS-1:0] w_wr_data [NUM_LSUS];

  assign w_req = bus.lsu_read_valid | bus.lsu_write_valid;

  for (genvar i = 0; i < NUM_LSUS; i++) begin : g_lane
    assign w_rd_addr[i] = bus.lsu_read_address[i*ADDR_BITS +: ADDR_BITS];
    assign w_wr_addr[i] = bus.lsu_write_address[i*ADDR_BITS +: ADDR_BITS];
    assign w_wr_data[i] = bus.lsu_write_data[i*DATA_BITS +: DATA_BITS];
    assign bus.lsu_read_data[i*DATA_BITS +: DATA_BITS] = r_rd_data[i];
  end

  // Descending scan so the requester closest to r_rr_ptr is the one kept.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_rr_ptr;
    w_sum  = '0;
    for (int k = NUM_LSUS - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (c_idx_w+1)'(k);
      if (w_sum >= c_num) w_sum = w_sum - c_num;
      if (w_req[w_sum[c_idx_w-1:0]]) begin
        w_hit  = 1'b1;
        w_pick = w_sum[c_idx_w-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:    if (w_hit) w_state_nxt = c_st_wait;
      c_st_wait:    if (bus.mem_ready || w_expire) w_state_nxt = c_st_release;
      c_st_release: w_state_nxt = c_st_idle;
      default:      w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_mem_valid_nxt   = r_mem_valid;
    w_mem_we_nxt      = r_mem_we;
    w_mem_address_nxt = r_mem_address;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_grant_nxt       = r_grant;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_rd_ready_nxt    = '0;
    w_wr_ready_nxt    = '0;
    w_rd_load         = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_hit) begin
          w_mem_valid_nxt = 1'b1;
          w_grant_nxt     = w_pick;
          // A write outranks a read raised by the same LSU.
          if (bus.lsu_write_valid[w_pick]) begin
            w_mem_we_nxt      = 1'b1;
            w_mem_address_nxt = w_wr_addr[w_pick];
            w_mem_wdata_nxt   = w_wr_data[w_pick];
          end else begin
            w_mem_we_nxt      = 1'b0;
            w_mem_address_nxt = w_rd_addr[w_pick];
          end
        end
      end
      c_st_wait: begin
        if (bus.mem_ready || w_expire) begin
          w_mem_valid_nxt = 1'b0;
          w_rr_ptr_nxt    = (r_grant == c_last) ? '0 : r_grant + c_idx_w'(1);
          if (r_mem_we) begin
            w_wr_ready_nxt[r_grant] = 1'b1;
          end else begin
            w_rd_ready_nxt[r_grant] = 1'b1;
            w_rd_load               = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_rd_value = bus.mem_ready ? bus.mem_rdata : '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_st_idle;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_rd_ready    <= '0;
      r_wr_ready    <= '0;
      r_busy        <= 1'b0;
      for (int i = 0; i < NUM_LSUS; i++) r_rd_data[i] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_mem_valid   <= w_mem_valid_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_rd_ready    <= w_rd_ready_nxt;
      r_wr_ready    <= w_wr_ready_nxt;
      r_busy        <= (w_state_nxt != c_st_idle);
      if (w_rd_load) r_rd_data[r_grant] <= w_rd_value;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

  logic [c_tmr_w-1:0] r_timer;
  logic               r_timeout_err;

  // Fires on the last permitted WAIT cycle when memory still has not answered.
  assign w_expire = (r_state == c_st_wait) && !bus.mem_ready && (r_timer == c_tmr_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timer <= (r_state == c_st_wait) ? r_timer + c_tmr_w'(1) : '0;
      if (w_expire) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.mem_valid      = r_mem_valid;
  assign bus.mem_we         = r_mem_we;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.lsu_read_ready = r_rd_ready;
  assign bus.lsu_write_ready = r_wr_ready;
  assign grant_id           = r_grant;
  assign busy               = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_arbiter
// Brief    : Randomized LSU/memory traffic against a transaction-level
//            round-robin reference model.
// Revision : 1.0
// ============================================================================
module tb_lsu_mem_arbiter;
  localparam int N    = 4;
  localparam int AB   = 8;
  localparam int DB   = 8;
  localparam int TMO  = 8;
  localparam int NCYC = 3000;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  lsu_mem_arbiter_if #(.NUM_LSUS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  lsu_mem_arbiter #(
    .NUM_LSUS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // LSU agents
  bit   [N-1:0]  rv, wv, p_rrdy, p_wrdy;
  logic [AB-1:0] raddr [N];
  logic [AB-1:0] waddr [N];
  logic [DB-1:0] wdata [N];
  bit            gen_en;

  // Memory agent
  logic [DB-1:0] mem_array [256];
  int            lat;
  bit            lat_active, mem_mute, fast;

  // Reference model
  logic [DB-1:0] ref_mem [256];
  logic [DB-1:0] exp_rd [N];
  bit   [N-1:0]  exp_rrdy, exp_wrdy;
  bit            m_active, m_we, m_terr;
  int            m_grant, m_rr, m_free_at, m_start;
  logic [AB-1:0] m_addr;
  logic [DB-1:0] m_wdata;

  int  grant_log[$];
  bit  prev_valid;
  bit  did_rst;

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.lsu_read_address[i*AB +: AB]  = raddr[i];
      bus.lsu_write_address[i*AB +: AB] = waddr[i];
      bus.lsu_write_data[i*DB +: DB]    = wdata[i];
    end
    bus.lsu_read_valid  = rv;
    bus.lsu_write_valid = wv;
  endtask

  function automatic logic [N*DB-1:0] packed_exp_rd();
    logic [N*DB-1:0] v;
    for (int i = 0; i < N; i++) v[i*DB +: DB] = exp_rd[i];
    return v;
  endfunction

  // One edge of the reference: inputs currently on the bus are those just sampled.
  task automatic model_step();
    bit tmo;
    int idx;
    tmo      = 1'b0;
    exp_rrdy = '0;
    exp_wrdy = '0;
    if (m_active) begin
`ifdef ARB_TIMEOUT_EN
      tmo = !bus.mem_ready && (cyc - m_start == TMO);
`endif
      if (bus.mem_ready || tmo) begin
        if (m_we) begin
          exp_wrdy[m_grant] = 1'b1;
          if (!tmo) ref_mem[m_addr] = m_wdata;
        end else begin
          exp_rrdy[m_grant] = 1'b1;
          exp_rd[m_grant]   = tmo ? {DB{1'b1}} : ref_mem[m_addr];
        end
        if (tmo) m_terr = 1'b1;
        m_active  = 1'b0;
        m_rr      = (m_grant + 1) % N;
        m_free_at = cyc + 2;
      end
    end else if (cyc >= m_free_at) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!m_active && (rv[idx] || wv[idx])) begin
          m_active = 1'b1;
          m_grant  = idx;
          m_we     = wv[idx];
          m_addr   = wv[idx] ? waddr[idx] : raddr[idx];
          m_wdata  = wdata[idx];
          m_start  = cyc;
        end
      end
    end
  endtask

  task automatic run_checks();
    check_value("mem_valid", bus.mem_valid, m_active);
    if (m_active) begin
      check_value("mem_we", bus.mem_we, m_we);
      check_value("mem_address", bus.mem_address, m_addr);
      check_value("grant_id", grant_id, m_grant);
      if (m_we) check_value("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check_value("read_ready", bus.lsu_read_ready, exp_rrdy);
    check_value("write_ready", bus.lsu_write_ready, exp_wrdy);
    check_value("read_data", bus.lsu_read_data, packed_exp_rd());
    check_value("busy", busy, m_active || (cyc + 1 < m_free_at));
    check_value("timeout_err", timeout_err, m_terr);
  endtask

  task automatic agents_step();
    int kind;
    for (int i = 0; i < N; i++) begin
      if (p_rrdy[i]) rv[i] = 1'b0;
      if (p_wrdy[i]) wv[i] = 1'b0;
    end
    p_rrdy = bus.lsu_read_ready;
    p_wrdy = bus.lsu_write_ready;
    if (gen_en) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && !wv[i] && $urandom_range(0, 3) == 0) begin
          kind = $urandom_range(0, 2);
          if (kind != 1) begin rv[i] = 1'b1; raddr[i] = AB'($urandom_range(0, 15)); end
          if (kind != 0) begin
            wv[i] = 1'b1; waddr[i] = AB'($urandom_range(0, 15)); wdata[i] = DB'($urandom);
          end
        end
      end
    end
    drive_bus();
    if (mem_mute) begin
      bus.mem_ready = 1'b0;
    end else if (bus.mem_valid) begin
      if (!lat_active) begin
        lat_active = 1'b1;
        lat = fast ? 0 : $urandom_range(0, 3);
      end
      if (lat == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = mem_array[bus.mem_address];
        if (bus.mem_we) mem_array[bus.mem_address] = bus.mem_wdata;
        lat_active = 1'b0;
      end else begin
        lat--;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = DB'($urandom);
      end
    end else begin
      lat_active    = 1'b0;
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = DB'($urandom);
    end
  endtask

  initial begin
    logic [15:0] order;
    for (int a = 0; a < 256; a++) begin
      mem_array[a] = DB'($urandom);
      ref_mem[a]   = mem_array[a];
    end
    for (int i = 0; i < N; i++) begin
      exp_rd[i] = '0; raddr[i] = AB'(8'h40 + i); waddr[i] = '0; wdata[i] = '0;
    end
    rv = '1; wv = '0; p_rrdy = '0; p_wrdy = '0;
    gen_en = 1'b0; fast = 1'b1; mem_mute = 1'b0; lat_active = 1'b0; lat = 0;
    m_active = 1'b0; m_we = 1'b0; m_terr = 1'b0; m_grant = 0; m_rr = 0;
    m_free_at = 0; m_start = 0; m_addr = '0; m_wdata = '0;
    prev_valid = 1'b0; did_rst = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    drive_bus();

    #3;
    check_value("reset_mem_valid", bus.mem_valid, 1'b0);
    check_value("reset_busy", busy, 1'b0);
    check_value("reset_grant_id", grant_id, 2'd0);
    check_value("reset_read_data", bus.lsu_read_data, '0);
    check_value("reset_ready", {bus.lsu_read_ready, bus.lsu_write_ready}, '0);
    #9 reset = 1'b0;

    repeat (NCYC) begin
      @(posedge clk);
      #1;
      model_step();
      run_checks();
      if (bus.mem_valid && !prev_valid) grant_log.push_back(int'(grant_id));
      prev_valid = bus.mem_valid;

      if (cyc == 12) begin
        order = '1;
        for (int g = 0; g < 4 && g < grant_log.size(); g++) order[15-4*g -: 4] = 4'(grant_log[g]);
        check_value("fair_order", order, 16'h0123);
        gen_en = 1'b1;
        fast   = 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      if (cyc == 2500) begin
        gen_en   = 1'b0;
        mem_mute = 1'b1;
        rv[0] = 1'b1;
        raddr[0] = 8'h20;
      end
`endif
      agents_step();

      // Asynchronous reset in the middle of a WAIT, away from any clock edge.
      if (!did_rst && cyc > 1500 && m_active && !bus.mem_ready) begin
        did_rst = 1'b1;
        #2 reset = 1'b1;
        #1;
        check_value("midrst_mem_valid", bus.mem_valid, 1'b0);
        check_value("midrst_busy", busy, 1'b0);
        check_value("midrst_read_data", bus.lsu_read_data, '0);
        #2 reset = 1'b0;
        m_active = 1'b0; m_rr = 0; m_free_at = 0; m_terr = 1'b0;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        lat_active = 1'b0; p_rrdy = '0; p_wrdy = '0; prev_valid = 1'b0;
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
